trace_reader: RTL and testbench
===============================

TRACE_READER -- requirements
Module: trace_reader

Interface
REQ-001 Parameter depth, default 1024: number of trace buffer entries to be addressed.
REQ-002 Parameter width, default 64: width of a reassembled trace entry.
REQ-003 Parameter owidth, default 32: width of one transfer beat; width SHALL equal 2*owidth.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 start__ENA / start__RDY  input / output  1 / 1  begin a readout; accepted when both high.
REQ-007 start$base  input  $clog2(depth)  first entry address.
REQ-008 start$count  input  $clog2(depth)+1  entries to read, range 0..depth.
REQ-009 req.enq__ENA / req.enq__RDY  output / input  1 / 1  address request to the trace buffer.
REQ-010 req.enq$v  output  owidth  zero-extended entry address.
REQ-011 rsp.enq__ENA / rsp.enq__RDY  input / output  1 / 1  returned data beat.
REQ-012 rsp.enq$v  input  owidth  data beat, low half first, then high half.
REQ-013 out.enq__ENA / out.enq__RDY  output / input  1 / 1  reassembled entry to consumer.
REQ-014 out.enq$v  output  width  {high beat, low beat}.
REQ-015 done  output  1  one-cycle pulse when a readout completes or aborts.
REQ-016 error  output  1  sticky; set on timeout (see Configuration), cleared by start acceptance.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, LOW, HIGH, EMIT.
REQ-018 IDLE: start__RDY=1; on accept with count=0 -> stay IDLE, pulse done next cycle; count>0 -> latch base/count, go ISSUE.
REQ-019 ISSUE: req.enq__ENA=1 with current address; on req.enq__RDY -> LOW.
REQ-020 LOW: rsp.enq__RDY=1; on beat, capture low half -> HIGH.
REQ-021 HIGH: rsp.enq__RDY=1; on beat, capture high half -> EMIT.
REQ-022 EMIT: out.enq__ENA=1 holding stable data until out.enq__RDY; on transfer decrement remaining, increment address; remaining reaches 0 -> IDLE with done pulse the same cycle as the final transfer, else -> ISSUE.
REQ-023 Address SHALL wrap modulo depth (depth-1 + 1 = 0).
REQ-024 At most one request SHALL be outstanding; rsp.enq__RDY=0 in IDLE, ISSUE, EMIT.
REQ-025 Response beats presented while rsp.enq__RDY=0 SHALL not be consumed and SHALL not alter state.
REQ-026 start__RDY=0 in every state except IDLE; start__ENA outside IDLE is ignored.
REQ-027 Per-entry minimum latency: ISSUE accept to out.enq__ENA = 3 cycles when rsp beats arrive back-to-back.

Reset
REQ-028 RST high at a clock edge SHALL force IDLE from any state, including mid-entry.
REQ-029 Reset values: all __ENA outputs 0, rsp.enq__RDY 0, start__RDY 1 from first post-reset cycle, done 0, error 0, out.enq$v 0, address and remaining 0.
REQ-030 A partially captured entry SHALL be discarded on reset and never emitted.

Configuration
REQ-031 Macro TRACE_READER_TIMEOUT_EN defined: an 8-bit watchdog counts cycles spent in LOW or HIGH without a beat, clears on each beat; reaching 255 -> set error, pulse done, go IDLE, discard partial entry.
REQ-032 Macro undefined: no watchdog logic; LOW/HIGH wait indefinitely; error SHALL be tied 0.

Verification
REQ-033 Reset then start base=5 count=2, responder returns beats 0x11111111,0x22222222,0x33333333,0x44444444 -> req addrs 5,6; out 0x2222222211111111 then 0x4444444433333333; done one pulse.
REQ-034 start base=1023 count=3 -> req addrs 1023, 0, 1.
REQ-035 start count=0 -> no req.enq__ENA, done pulse one cycle after accept, start__RDY remains 1.
REQ-036 out.enq__RDY held low 10 cycles in EMIT -> out.enq$v stable, no new req issued, rsp.enq__RDY=0 throughout.
REQ-037 RST asserted in HIGH after low beat 0xAAAAAAAA -> next cycle IDLE, no out.enq__ENA, subsequent readout emits only fresh data.
REQ-038 With TRACE_READER_TIMEOUT_EN, responder silent after request -> error=1 and done pulse 255 cycles after entering LOW; error clears on next start accept.

Source files
------------

// File: rtl/trace_reader.sv
// trace_reader: reads a run of entries out of a trace buffer and hands them to a consumer.
//
// Each entry is fetched by issuing one address request and collecting two response beats
// (low half first, then high half). The two halves are reassembled into one out beat.
// Only one request is in flight at a time.
//
// Ports
//   CLK, RST                    clock; synchronous active-high reset
//   start__ENA / start__RDY     begin a readout (accepted when both high, only in idle)
//   start_base, start_count     first entry address; number of entries (0..depth)
//   req_enq__ENA/__RDY, _v      address request to the trace buffer (zero-extended address)
//   rsp_enq__ENA/__RDY, _v      returned data beats, low half then high half
//   out_enq__ENA/__RDY, _v      reassembled entry {high, low} to the consumer
//   done                        one-cycle pulse when a readout completes or aborts
//   error                       sticky timeout flag, cleared when a start is accepted
//
// Optional feature
//   TRACE_READER_TIMEOUT_EN     when defined, an 8-bit watchdog aborts a readout that waits
//                               255 cycles for a response beat; when undefined, error is 0.
//
// width must equal 2*owidth, and owidth must be at least $clog2(depth).

module trace_reader #(
    parameter int unsigned depth  = 1024,
    parameter int unsigned width  = 64,
    parameter int unsigned owidth = 32
) (
    input  logic                       CLK,
    input  logic                       RST,

    input  logic                       start__ENA,
    output logic                       start__RDY,
    input  logic [$clog2(depth)-1:0]   start_base,
    input  logic [$clog2(depth):0]     start_count,

    output logic                       req_enq__ENA,
    input  logic                       req_enq__RDY,
    output logic [owidth-1:0]          req_enq_v,

    input  logic                       rsp_enq__ENA,
    output logic                       rsp_enq__RDY,
    input  logic [owidth-1:0]          rsp_enq_v,

    output logic                       out_enq__ENA,
    input  logic                       out_enq__RDY,
    output logic [width-1:0]           out_enq_v,

    output logic                       done,
    output logic                       error
);

    localparam int unsigned AW = $clog2(depth);
    localparam logic [AW-1:0] AddrMax = AW'(depth - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StLow,
        StHigh,
        StEmit
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW:0]         rem_q, rem_d;
    logic [owidth-1:0]   low_q, low_d;
    logic [width-1:0]    data_q, data_d;
    logic                done_q, done_d;
    logic                done_now;

`ifdef TRACE_READER_TIMEOUT_EN
    logic [7:0]          wd_q, wd_d;
    logic                error_q, error_d;
`endif

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        low_d        = low_q;
        data_d       = data_q;
        done_d       = 1'b0;
        done_now     = 1'b0;
        start__RDY   = 1'b0;
        req_enq__ENA = 1'b0;
        rsp_enq__RDY = 1'b0;
        out_enq__ENA = 1'b0;
`ifdef TRACE_READER_TIMEOUT_EN
        wd_d         = '0;
        error_d      = error_q;
`endif

        unique case (state_q)
            StIdle: begin
                start__RDY = 1'b1;
                if (start__ENA) begin
`ifdef TRACE_READER_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    if (start_count == '0) begin
                        // Empty readout: nothing to fetch, just report completion.
                        done_d = 1'b1;
                    end else begin
                        addr_d  = start_base;
                        rem_d   = start_count;
                        state_d = StIssue;
                    end
                end
            end

            StIssue: begin
                req_enq__ENA = 1'b1;
                if (req_enq__RDY) begin
                    state_d = StLow;
                end
            end

            StLow: begin
                rsp_enq__RDY = 1'b1;
                if (rsp_enq__ENA) begin
                    low_d   = rsp_enq_v;
                    state_d = StHigh;
                end
            end

            StHigh: begin
                rsp_enq__RDY = 1'b1;
                if (rsp_enq__ENA) begin
                    data_d  = {rsp_enq_v, low_q};
                    state_d = StEmit;
                end
            end

            StEmit: begin
                // data_q is held untouched until the consumer takes it.
                out_enq__ENA = 1'b1;
                if (out_enq__RDY) begin
                    rem_d  = rem_q - 1'b1;
                    addr_d = (addr_q == AddrMax) ? '0 : addr_q + 1'b1;
                    if (rem_q == (AW+1)'(1)) begin
                        done_now = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef TRACE_READER_TIMEOUT_EN
        // Watchdog: counts consecutive cycles waiting for a beat; the 255th idle wait aborts.
        if ((state_q == StLow || state_q == StHigh) && !rsp_enq__ENA) begin
            wd_d = wd_q + 8'd1;
            if (wd_q == 8'd254) begin
                wd_d    = '0;
                low_d   = '0;
                error_d = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end
        end
`endif
    end

    assign req_enq_v = owidth'(addr_q);
    assign out_enq_v = data_q;
    // Completion on the final transfer is immediate; empty readouts and aborts are registered.
    assign done      = done_q | done_now;

`ifdef TRACE_READER_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            low_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef TRACE_READER_TIMEOUT_EN
            wd_q    <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            low_q   <= low_d;
            data_q  <= data_d;
            done_q  <= done_d;
`ifdef TRACE_READER_TIMEOUT_EN
            wd_q    <= wd_d;
            error_q <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_trace_reader.sv
// Directed bench for trace_reader (default parameters). Inputs change 1 time unit after a
// rising edge; outputs are checked in the same window, well away from the next edge.

module tb_trace_reader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start__ENA;
    logic        start__RDY;
    logic [9:0]  start_base;
    logic [10:0] start_count;
    logic        req_enq__ENA;
    logic        req_enq__RDY;
    logic [31:0] req_enq_v;
    logic        rsp_enq__ENA;
    logic        rsp_enq__RDY;
    logic [31:0] rsp_enq_v;
    logic        out_enq__ENA;
    logic        out_enq__RDY;
    logic [63:0] out_enq_v;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_err = 0;

    trace_reader dut (
        .CLK          (CLK),
        .RST          (RST),
        .start__ENA   (start__ENA),
        .start__RDY   (start__RDY),
        .start_base   (start_base),
        .start_count  (start_count),
        .req_enq__ENA (req_enq__ENA),
        .req_enq__RDY (req_enq__RDY),
        .req_enq_v    (req_enq_v),
        .rsp_enq__ENA (rsp_enq__ENA),
        .rsp_enq__RDY (rsp_enq__RDY),
        .rsp_enq_v    (rsp_enq_v),
        .out_enq__ENA (out_enq__ENA),
        .out_enq__RDY (out_enq__RDY),
        .out_enq_v    (out_enq_v),
        .done         (done),
        .error        (error)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept a start in the current (idle) cycle.
    task automatic do_start(input logic [9:0] base, input logic [10:0] count);
        chk("start_rdy_idle", 64'(start__RDY), 64'd1);
        start__ENA  = 1'b1;
        start_base  = base;
        start_count = count;
        tick();
        start__ENA  = 1'b0;
    endtask

    // One full entry starting in ISSUE: request, two beats, optional consumer stall, transfer.
    task automatic do_entry(input logic [31:0] exp_addr, input logic [31:0] lo,
                            input logic [31:0] hi, input int stall, input bit last);
        chk("req_ena", 64'(req_enq__ENA), 64'd1);
        chk("req_addr", 64'(req_enq_v), 64'(exp_addr));
        chk("rsp_rdy_issue", 64'(rsp_enq__RDY), 64'd0);
        chk("start_rdy_busy", 64'(start__RDY), 64'd0);
        // A beat offered while not ready must be ignored.
        rsp_enq__ENA = 1'b1;
        rsp_enq_v    = 32'hdeadbeef;
        tick();
        rsp_enq__ENA = 1'b0;
        chk("req_ena_hold", 64'(req_enq__ENA), 64'd1);
        chk("req_addr_hold", 64'(req_enq_v), 64'(exp_addr));
        req_enq__RDY = 1'b1;
        tick();
        req_enq__RDY = 1'b0;
        chk("req_ena_low", 64'(req_enq__ENA), 64'd0);
        chk("rsp_rdy_low", 64'(rsp_enq__RDY), 64'd1);
        rsp_enq__ENA = 1'b1;
        rsp_enq_v    = lo;
        tick();
        chk("rsp_rdy_high", 64'(rsp_enq__RDY), 64'd1);
        rsp_enq_v    = hi;
        tick();
        rsp_enq__ENA = 1'b0;
        chk("out_ena", 64'(out_enq__ENA), 64'd1);
        chk("out_data", out_enq_v, {hi, lo});
        chk("rsp_rdy_emit", 64'(rsp_enq__RDY), 64'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_out_ena", 64'(out_enq__ENA), 64'd1);
            chk("stall_out_data", out_enq_v, {hi, lo});
            chk("stall_req_ena", 64'(req_enq__ENA), 64'd0);
            chk("stall_rsp_rdy", 64'(rsp_enq__RDY), 64'd0);
        end
        out_enq__RDY = 1'b1;
        #1;
        chk("done_on_xfer", 64'(done), 64'(last));
        tick();
        out_enq__RDY = 1'b0;
    endtask

    initial begin
        RST          = 1'b1;
        start__ENA   = 1'b0;
        start_base   = '0;
        start_count  = '0;
        req_enq__RDY = 1'b0;
        rsp_enq__ENA = 1'b0;
        rsp_enq_v    = '0;
        out_enq__RDY = 1'b0;
        tick();
        tick();
        RST = 1'b0;

        // Reset values
        chk("rst_start_rdy", 64'(start__RDY), 64'd1);
        chk("rst_req_ena", 64'(req_enq__ENA), 64'd0);
        chk("rst_rsp_rdy", 64'(rsp_enq__RDY), 64'd0);
        chk("rst_out_ena", 64'(out_enq__ENA), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_out_data", out_enq_v, 64'd0);
        chk("rst_req_addr", 64'(req_enq_v), 64'd0);

        // base=5 count=2, the second entry with a 10-cycle consumer stall
        do_start(10'd5, 11'd2);
        do_entry(32'd5, 32'h11111111, 32'h22222222, 0, 1'b0);
        do_entry(32'd6, 32'h33333333, 32'h44444444, 10, 1'b1);
        chk("idle_after_2", 64'(start__RDY), 64'd1);
        chk("done_single", 64'(done), 64'd0);

        // Address wrap: 1023, 0, 1
        do_start(10'd1023, 11'd3);
        do_entry(32'd1023, 32'h01020304, 32'h05060708, 0, 1'b0);
        do_entry(32'd0, 32'h0a0b0c0d, 32'h0e0f1011, 0, 1'b0);
        do_entry(32'd1, 32'h12345678, 32'h9abcdef0, 0, 1'b1);
        chk("idle_after_wrap", 64'(start__RDY), 64'd1);

        // Empty readout: done one cycle after accept, no request
        do_start(10'd40, 11'd0);
        chk("cnt0_done", 64'(done), 64'd1);
        chk("cnt0_req_ena", 64'(req_enq__ENA), 64'd0);
        chk("cnt0_start_rdy", 64'(start__RDY), 64'd1);
        tick();
        chk("cnt0_done_clr", 64'(done), 64'd0);
        chk("cnt0_req_ena2", 64'(req_enq__ENA), 64'd0);

        // Reset mid-entry after the low beat
        do_start(10'd7, 11'd1);
        req_enq__RDY = 1'b1;
        tick();
        req_enq__RDY = 1'b0;
        rsp_enq__ENA = 1'b1;
        rsp_enq_v    = 32'haaaaaaaa;
        tick();
        rsp_enq__ENA = 1'b0;
        chk("mid_in_high", 64'(rsp_enq__RDY), 64'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_start_rdy", 64'(start__RDY), 64'd1);
        chk("mid_rst_out_ena", 64'(out_enq__ENA), 64'd0);
        chk("mid_rst_rsp_rdy", 64'(rsp_enq__RDY), 64'd0);
        chk("mid_rst_out_data", out_enq_v, 64'd0);
        chk("mid_rst_addr", 64'(req_enq_v), 64'd0);
        tick();
        chk("mid_rst_out_ena2", 64'(out_enq__ENA), 64'd0);
        do_start(10'd9, 11'd1);
        do_entry(32'd9, 32'h55555555, 32'h66666666, 0, 1'b1);

`ifdef TRACE_READER_TIMEOUT_EN
        // Silent responder: abort 255 cycles after entering LOW
        do_start(10'd3, 11'd1);
        req_enq__RDY = 1'b1;
        tick();
        req_enq__RDY = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        chk("wd_pre_error", 64'(error), 64'd0);
        chk("wd_pre_done", 64'(done), 64'd0);
        chk("wd_pre_rsp_rdy", 64'(rsp_enq__RDY), 64'd1);
        tick();
        chk("wd_error", 64'(error), 64'd1);
        chk("wd_done", 64'(done), 64'd1);
        chk("wd_idle", 64'(start__RDY), 64'd1);
        chk("wd_out_ena", 64'(out_enq__ENA), 64'd0);
        tick();
        chk("wd_done_clr", 64'(done), 64'd0);
        chk("wd_error_sticky", 64'(error), 64'd1);
        do_start(10'd0, 11'd0);
        chk("wd_error_clr", 64'(error), 64'd0);
`else
        chk("error_tied", 64'(error), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
